// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the load/store
// unit (port 0) and the debug/loader port (port 1); one access in flight.
module dmem_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_err,

   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_err,

   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writeData,
   input  logic [DATA_W-1:0] mem_readData
);

   // Handshake: a requester raises rN_req with we/addr/wdata valid and holds it
   // until rN_ack; those inputs are captured only on the grant edge. rN_ack is a
   // one-cycle pulse carrying rN_rdata/rN_err; req must drop the cycle after ack.

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic              prio_q,  prio_d;
   logic              gnt_q,   gnt_d;
   logic              we_q,    we_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q,   err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              sel;
   logic              in_range;
   logic              in_access;
   logic              in_done;

   // Unsigned compare on a widened copy so DEPTH == 2**ADDR_W cannot wrap.
   assign in_range  = ({1'b0, addr_q} < DEPTH_EXT);
   assign in_access = (state_q == ST_ACCESS);
   assign in_done   = (state_q == ST_DONE);

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      sel     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (r0_req || r1_req) begin
               sel     = (r0_req && r1_req) ? prio_q : r1_req;
               gnt_d   = sel;
               we_d    = sel ? r1_we    : r0_we;
               addr_d  = sel ? r1_addr  : r0_addr;
               wdata_d = sel ? r1_wdata : r0_wdata;
               err_d   = 1'b0;
               rdata_d = '0;
               state_d = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            err_d   = !in_range;
            rdata_d = (in_range && !we_q) ? mem_readData : '0;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            prio_d  = !gnt_q;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         prio_q  <= 1'b0;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Address/data come straight from the grant latches, so they are stable for
   // the whole ACCESS cycle and simply hold their last value otherwise.
   assign MemRead       = in_access && in_range && !we_q;
   assign MemWrite      = in_access && in_range &&  we_q;
   assign mem_address   = addr_q;
   assign mem_writeData = wdata_q;

   assign r0_ack   = in_done && !gnt_q;
   assign r1_ack   = in_done &&  gnt_q;
   assign r0_rdata = r0_ack ? rdata_q : '0;
   assign r1_rdata = r1_ack ? rdata_q : '0;
   assign r0_err   = r0_ack && err_q;
   assign r1_err   = r1_ack && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a 32-word memory model behind the arbiter,
// linear stimulus steps and immediate assertions at every checkpoint.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        r0_req, r0_we, r0_ack, r0_err;
   logic [31:0] r0_addr, r0_wdata, r0_rdata;
   logic        r1_req, r1_we, r1_ack, r1_err;
   logic [31:0] r1_addr, r1_wdata, r1_rdata;
   logic        MemRead, MemWrite;
   logic [31:0] mem_address, mem_writeData, mem_readData;

   logic [31:0] mem [0:31];

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .r0_req        (r0_req),
      .r0_we         (r0_we),
      .r0_addr       (r0_addr),
      .r0_wdata      (r0_wdata),
      .r0_ack        (r0_ack),
      .r0_rdata      (r0_rdata),
      .r0_err        (r0_err),
      .r1_req        (r1_req),
      .r1_we         (r1_we),
      .r1_addr       (r1_addr),
      .r1_wdata      (r1_wdata),
      .r1_ack        (r1_ack),
      .r1_rdata      (r1_rdata),
      .r1_err        (r1_err),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .mem_address   (mem_address),
      .mem_writeData (mem_writeData),
      .mem_readData  (mem_readData)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: word i powers up as 0xA000_0000 + i, refilled on reset.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      end else if (MemWrite && mem_address < 32) begin
         mem[mem_address[4:0]] <= mem_writeData;
      end
   end

   assign mem_readData = (mem_address < 32) ? mem[mem_address[4:0]] : 32'h0;

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_r0(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      r0_req   = req;
      r0_we    = we;
      r0_addr  = addr;
      r0_wdata = wdata;
   endtask

   task automatic drive_r1(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      r1_req   = req;
      r1_we    = we;
      r1_addr  = addr;
      r1_wdata = wdata;
   endtask

   initial begin
      logic        exp_port;
      logic [31:0] exp_addr;

      reset = 1'b1;
      drive_r0(1'b0, 1'b0, 32'h0, 32'h0);
      drive_r1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();

      // Reset state
      check("rst_r0_ack",   32'(r0_ack),   32'h0);
      check("rst_r1_ack",   32'(r1_ack),   32'h0);
      check("rst_r0_rdata", r0_rdata,      32'h0);
      check("rst_r1_err",   32'(r1_err),   32'h0);
      check("rst_memread",  32'(MemRead),  32'h0);
      check("rst_memwrite", 32'(MemWrite), 32'h0);
      check("rst_addr",     mem_address,   32'h0);
      check("rst_wdata",    mem_writeData, 32'h0);
      reset = 1'b0;
      tick();

      // r0 writes 0xDEADBEEF to address 5
      drive_r0(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
      tick();
      check("wr_acc_memwrite", 32'(MemWrite), 32'h1);
      check("wr_acc_memread",  32'(MemRead),  32'h0);
      check("wr_acc_addr",     mem_address,   32'd5);
      check("wr_acc_wdata",    mem_writeData, 32'hDEAD_BEEF);
      check("wr_acc_ack",      32'(r0_ack),   32'h0);
      tick();
      check("wr_done_memwrite", 32'(MemWrite), 32'h0);
      check("wr_done_ack",      32'(r0_ack),   32'h1);
      check("wr_done_rdata",    r0_rdata,      32'h0);
      check("wr_done_err",      32'(r0_err),   32'h0);
      check("wr_done_r1_ack",   32'(r1_ack),   32'h0);
      drive_r0(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      check("wr_idle_ack", 32'(r0_ack), 32'h0);

      // r1 reads address 5 back
      drive_r1(1'b1, 1'b0, 32'd5, 32'h0);
      tick();
      check("rd_acc_memread",  32'(MemRead),  32'h1);
      check("rd_acc_memwrite", 32'(MemWrite), 32'h0);
      check("rd_acc_addr",     mem_address,   32'd5);
      tick();
      check("rd_done_ack",    32'(r1_ack),  32'h1);
      check("rd_done_rdata",  r1_rdata,     32'hDEAD_BEEF);
      check("rd_done_err",    32'(r1_err),  32'h0);
      check("rd_done_r0_ack", 32'(r0_ack),  32'h0);
      check("rd_done_r0_rd",  r0_rdata,     32'h0);
      drive_r1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Both ports hold req: grants alternate r0, r1, r0, r1, acks every 3 cycles
      drive_r0(1'b1, 1'b0, 32'd10, 32'h0);
      drive_r1(1'b1, 1'b0, 32'd20, 32'h0);
      for (int k = 0; k < 4; k++) begin
         exp_port = k[0];
         exp_addr = exp_port ? 32'd20 : 32'd10;
         tick();
         check("rr_acc_addr",    mem_address,   exp_addr);
         check("rr_acc_memread", 32'(MemRead),  32'h1);
         check("rr_acc_noack",   32'({r1_ack, r0_ack}), 32'h0);
         tick();
         check("rr_done_r0_ack", 32'(r0_ack), 32'(!exp_port));
         check("rr_done_r1_ack", 32'(r1_ack), 32'(exp_port));
         check("rr_done_rdata",  exp_port ? r1_rdata : r0_rdata, 32'hA000_0000 + exp_addr);
         check("rr_done_idle_rdata", exp_port ? r0_rdata : r1_rdata, 32'h0);
         if (k == 3) begin
            drive_r0(1'b0, 1'b0, 32'h0, 32'h0);
            drive_r1(1'b0, 1'b0, 32'h0, 32'h0);
         end
         tick();
         check("rr_idle_acks", 32'({r1_ack, r0_ack}), 32'h0);
      end

      // Out-of-range read at 32, then boundary read at 31
      drive_r0(1'b1, 1'b0, 32'd32, 32'h0);
      tick();
      check("oor_acc_memread",  32'(MemRead),  32'h0);
      check("oor_acc_memwrite", 32'(MemWrite), 32'h0);
      check("oor_acc_addr",     mem_address,   32'd32);
      tick();
      check("oor_done_ack",   32'(r0_ack), 32'h1);
      check("oor_done_err",   32'(r0_err), 32'h1);
      check("oor_done_rdata", r0_rdata,    32'h0);
      drive_r0(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      drive_r0(1'b1, 1'b0, 32'd31, 32'h0);
      tick();
      check("edge_acc_memread", 32'(MemRead), 32'h1);
      tick();
      check("edge_done_ack",   32'(r0_ack), 32'h1);
      check("edge_done_err",   32'(r0_err), 32'h0);
      check("edge_done_rdata", r0_rdata,    32'hA000_001F);
      drive_r0(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Reset during ACCESS aborts the write; prio returns to port 0
      drive_r0(1'b1, 1'b1, 32'd9, 32'h1234_5678);
      tick();
      check("abort_acc_memwrite", 32'(MemWrite), 32'h1);
      reset = 1'b1;
      drive_r0(1'b1, 1'b0, 32'd4, 32'h0);
      drive_r1(1'b1, 1'b0, 32'd6, 32'h0);
      tick();
      check("abort_memwrite", 32'(MemWrite), 32'h0);
      check("abort_r0_ack",   32'(r0_ack),   32'h0);
      check("abort_addr",     mem_address,   32'h0);
      reset = 1'b0;
      tick();
      check("post_rst_addr", mem_address, 32'd4);
      check("post_rst_rd",   32'(MemRead), 32'h1);
      tick();
      check("post_rst_r0_ack", 32'(r0_ack), 32'h1);
      check("post_rst_r1_ack", 32'(r1_ack), 32'h0);
      check("post_rst_rdata",  r0_rdata,    32'hA000_0004);
      drive_r0(1'b0, 1'b0, 32'h0, 32'h0);
      drive_r1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // r1 changes its address during ACCESS; the strobe keeps address 3
      drive_r1(1'b1, 1'b0, 32'd3, 32'h0);
      tick();
      check("hold_acc_addr", mem_address,  32'd3);
      check("hold_acc_rd",   32'(MemRead), 32'h1);
      drive_r1(1'b0, 1'b0, 32'd7, 32'h0);
      #4;
      check("hold_mid_addr", mem_address,  32'd3);
      check("hold_mid_rd",   32'(MemRead), 32'h1);
      tick();
      check("hold_done_ack",   32'(r1_ack), 32'h1);
      check("hold_done_rdata", r1_rdata,    32'hA000_0003);
      tick();
      check("hold_idle_ack",  32'(r1_ack),  32'h0);
      check("hold_idle_rd",   32'(MemRead), 32'h0);
      check("hold_idle_addr", mem_address,  32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (load/store unit) and port 1 (debug/loader port).
- Round-robin arbitration; one transaction in flight; fixed 3-cycle request-to-ack latency.
- Sits between the requesters and the data memory. Drives the memory's MemRead/MemWrite/address/writeData and returns its readData.
- Guarantees MemRead and MemWrite are single-cycle, mutually exclusive strobes with address/data stable for the whole strobe.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, requester and memory address width (word index)
- DEPTH, 32, number of memory words; addresses >= DEPTH are rejected

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- r0_req  input  1  port 0 request; held high until r0_ack
- r0_we  input  1  port 0: 1 = write, 0 = read
- r0_addr  input  ADDR_W  port 0 word address
- r0_wdata  input  DATA_W  port 0 write data
- r0_ack  output  1  port 0 completion pulse, one cycle
- r0_rdata  output  DATA_W  port 0 read data, valid with r0_ack
- r0_err  output  1  port 0 out-of-range flag, valid with r0_ack
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata, r1_err: same widths and meaning for port 1
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- mem_address  output  ADDR_W  memory address
- mem_writeData  output  DATA_W  memory write data
- mem_readData  input  DATA_W  memory read data (combinational from memory)

Behaviour:
- Reset (synchronous): state = IDLE and prio = 0 (port 0 favoured). All outputs are 0: acks, errs, rdata, MemRead, MemWrite, mem_address, mem_writeData.
- Reset asserted mid-transaction aborts it. No ack is issued. Strobes drop at the next edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port given by prio.
  - On grant: latch port id, we, addr, wdata into internal registers; go to ACCESS.
- ACCESS, exactly 1 cycle:
  - mem_address and mem_writeData come from the latched registers.
  - If the latched addr < DEPTH: MemRead = !we, MemWrite = we.
  - If addr >= DEPTH: no strobe; err is latched as 1.
  - On a read, capture mem_readData at the end of the cycle.
  - Go to DONE.
- DONE, exactly 1 cycle:
  - Pulse ack of the granted port only.
  - rdata = captured word for an in-range read; 0 for writes and errors.
  - err = latched err.
  - prio is set to the other port. Go to IDLE.
- Latency: req sampled in IDLE at edge N; ACCESS in cycle N+1; ack in cycle N+2. Minimum spacing between grants is 3 cycles.
- Port inputs are sampled only at grant. Later changes to them, or dropping req during ACCESS/DONE, do not affect the transaction; ack is still issued.
- The requester must drop req in the cycle after ack, or it is re-arbitrated as a new request.
- A req arriving during ACCESS/DONE waits; it is considered in the next IDLE cycle.
- The port not granted sees ack = 0 and rdata/err = 0.
- MemRead and MemWrite are never high together, and never high outside ACCESS.
- mem_address and mem_writeData hold their last value outside ACCESS; they are 0 after reset.
- Address comparison is unsigned full ADDR_W. No wrap-around: 32 is rejected, not mapped to 0.

Test Plan:
- Reset, then r0 writes 0xDEADBEEF to addr 5 → MemWrite high for exactly 1 cycle with mem_address = 5; r0_ack 2 cycles after the grant edge; r0_rdata = 0; r0_err = 0.
- r1 reads addr 5 after the above → MemRead one cycle; r1_ack with r1_rdata = 0xDEADBEEF; r0_ack stays 0.
- r0 and r1 both hold req continuously, each reading a different address → grants alternate r0, r1, r0, r1 (first grant r0 after reset); acks every 3 cycles; no port starved.
- r0 reads addr 32 → no MemRead/MemWrite strobe; r0_ack with r0_err = 1 and r0_rdata = 0. A following read of addr 31 → r0_err = 0.
- r0 write in progress; assert reset during ACCESS → MemWrite low next cycle, no r0_ack; after reset release, simultaneous requests grant r0 first.
- r1 changes r1_addr from 3 to 7 during ACCESS → memory sees address 3 for the whole strobe; ack returns the word at address 3.
